// File: rtl/glip_out_arbiter.sv
// glip_out_arbiter: round-robin arbiter that shares the GLIP Logic->Host FIFO
// channel between NUM_PORTS user-logic streams. Each grant covers a burst of
// at most MAX_BURST words. A single registered output stage sits between the
// requesters and the FX3 backend's fifo_out_ready.
module glip_out_arbiter #(
  parameter int WIDTH     = 16,
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 8,
  parameter int PORT_BITS = $clog2(NUM_PORTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_PORTS*WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]       in_valid,
  output logic [NUM_PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PORT_BITS-1:0]       out_port,
  output logic                       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state;
  logic [PORT_BITS-1:0] grant;
  logic [PORT_BITS-1:0] last;
  logic [PORT_BITS-1:0] pick;
  logic [7:0]           beat;
  logic                 stage_free;
  logic                 xfer;
  logic [WIDTH-1:0]     words [NUM_PORTS];

  // Slice the flat data bus into one word per requester.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_words
    assign words[i] = in_data[i*WIDTH +: WIDTH];
  end

  // The output stage can take a new word when it is empty or being drained.
  assign stage_free = !out_valid || out_ready;
  assign xfer       = (state == BURST) && in_valid[grant] && stage_free;
  assign busy       = (state == BURST);

  // Round-robin pick: the first valid port after `last`, with `last` itself
  // checked last. Scanning downwards lets the closest candidate win.
  always_comb begin
    int idx;
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    pick = last;
    idx  = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_PORTS;
      if (in_valid[idx[PORT_BITS-1:0]]) pick = idx[PORT_BITS-1:0];
    end
  end

  // Only the granted port is offered the output stage; never depends on in_valid.
  always_comb begin
    in_ready = '0;
    if ((state == BURST) && stage_free) in_ready[grant] = 1'b1;
  end

  // Arbitration FSM, burst counter and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      last      <= PORT_BITS'(NUM_PORTS - 1);
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_port  <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (out_ready) out_valid <= 1'b0;
          if (|in_valid) begin
            state <= BURST;
            grant <= pick;
          end
        end
        BURST: begin
          if (xfer) begin
            out_data  <= words[grant];
            out_port  <= grant;
            out_valid <= 1'b1;
            beat      <= beat + 8'd1;
            if (beat == 8'(MAX_BURST - 1)) begin
              state <= IDLE;
              last  <= grant;
            end
          end else if (stage_free) begin
            // Stage is free but the granted port has nothing: it ran dry.
            out_valid <= 1'b0;
            state     <= IDLE;
            last      <= grant;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glip_out_arbiter.sv
// tb_glip_out_arbiter: self-checking bench for glip_out_arbiter. Per-port
// source queues feed the DUT; the output log is compared against expectations
// derived from the round-robin / burst rules.
module tb_glip_out_arbiter;

  logic        clk;
  logic        rst_n;

  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_port;
  logic        busy;

  logic [31:0] e_in_data;
  logic [1:0]  e_in_valid;
  logic [1:0]  e_in_ready;
  logic [15:0] e_out_data;
  logic        e_out_valid;
  logic        e_out_ready;
  logic [0:0]  e_out_port;
  logic        e_busy;

  glip_out_arbiter #(.WIDTH(16), .NUM_PORTS(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_port(out_port), .busy(busy)
  );

  glip_out_arbiter #(.WIDTH(16), .NUM_PORTS(2), .MAX_BURST(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_data(e_in_data), .in_valid(e_in_valid),
    .in_ready(e_in_ready), .out_data(e_out_data), .out_valid(e_out_valid),
    .out_ready(e_out_ready), .out_port(e_out_port), .busy(e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  int          cyc;
  int          stab_err;
  int          inv_err;
  bit          rand_ready;
  bit          hold_prev;
  logic [15:0] hold_data;
  logic [1:0]  hold_port;

  logic [15:0] sq [4][$];
  logic [15:0] ow [$];
  logic [1:0]  op [$];
  int          oc [$];
  int          ac [$];

  function automatic logic [15:0] tag(input int p, input int s);
    return 16'(p * 256 + s);
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      in_valid[i]          = (sq[i].size() > 0);
      in_data[i*16 +: 16]  = (sq[i].size() > 0) ? sq[i][0] : 16'h0;
    end
  endtask

  // One clock: sample handshakes on the falling edge, retire on the rising edge.
  task automatic cycle();
    logic [3:0] acc;
    logic       fire;
    @(negedge clk);
    acc  = in_valid & in_ready;
    fire = out_valid & out_ready;
    if ((in_ready != 4'b0) && out_valid && !out_ready) inv_err++;
    if ($countones(in_ready) > 1) inv_err++;
    if (hold_prev && (!out_valid || out_data !== hold_data || out_port !== hold_port))
      stab_err++;
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    hold_port = out_port;
    if (fire) begin
      ow.push_back(out_data);
      op.push_back(out_port);
      oc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        void'(sq[i].pop_front());
        ac.push_back(cyc);
      end
    end
    cyc++;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    drive();
  endtask

  task automatic clear_logs();
    ow.delete(); op.delete(); oc.delete(); ac.delete();
    cyc = 0; hold_prev = 1'b0; stab_err = 0; inv_err = 0;
  endtask

  task automatic reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) sq[i].delete();
    out_ready  = 1'b1;
    rand_ready = 1'b0;
    e_in_valid = 2'b00;
    e_in_data  = '0;
    e_out_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (ow.size() < n && k < budget) begin
      cycle();
      k++;
    end
    total++;
    if (ow.size() < n) $display("FAIL timeout: got %0d words, want %0d", ow.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    total++; if (in_ready !== 4'b0) $display("FAIL rst_in_ready: got %b want 0000", in_ready); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL rst_out_data: got %h want 0000", out_data); else passed++;
    total++; if (out_port !== 2'd0) $display("FAIL rst_out_port: got %0d want 0", out_port); else passed++;
    sq[2].push_back(16'hABCD);
    drive();
    #1;
    total++; if (in_ready !== 4'b0) $display("FAIL idle_in_ready: got %b want 0000", in_ready); else passed++;
    cycle();
    total++; if (busy !== 1'b1) $display("FAIL grant_busy: got %b want 1", busy); else passed++;
    total++; if (in_ready !== 4'b0100) $display("FAIL grant_in_ready: got %b want 0100", in_ready); else passed++;
    run_until(1, 10);
    total++; if (ow[0] !== 16'hABCD) $display("FAIL first_word: got %h want abcd", ow[0]); else passed++;
    total++; if (op[0] !== 2'd2) $display("FAIL first_port: got %0d want 2", op[0]); else passed++;
  endtask

  task automatic test_single_port();
    reset();
    for (int s = 0; s < 24; s++) sq[2].push_back(16'(s));
    drive();
    run_until(24, 100);
    total++; if (ac[0] !== 1) $display("FAIL single_first_accept: got cycle %0d want 1", ac[0]); else passed++;
    for (int k = 0; k < 24; k++) begin
      total++; if (ow[k] !== 16'(k)) $display("FAIL single_data[%0d]: got %h want %h", k, ow[k], 16'(k)); else passed++;
      total++; if (op[k] !== 2'd2) $display("FAIL single_port[%0d]: got %0d want 2", k, op[k]); else passed++;
      // One arbitration bubble after every 8-word burst.
      total++; if (oc[k] !== 2 + k + k / 8) $display("FAIL single_cycle[%0d]: got %0d want %0d", k, oc[k], 2 + k + k / 8); else passed++;
    end
  endtask

  task automatic test_all_ports();
    reset();
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 16; s++) sq[p].push_back(tag(p, s));
    drive();
    run_until(40, 200);
    for (int k = 0; k < 40; k++) begin
      int b;
      int p;
      int s;
      b = k / 8;
      p = b % 4;
      s = (b / 4) * 8 + k % 8;
      total++; if (ow[k] !== tag(p, s) || op[k] !== 2'(p))
        $display("FAIL rr_word[%0d]: got %h port %0d want %h port %0d", k, ow[k], op[k], tag(p, s), p);
      else passed++;
    end
    total++; if (inv_err !== 0) $display("FAIL rr_in_ready_rule: got %0d violations want 0", inv_err); else passed++;
  endtask

  task automatic test_backpressure();
    int next_s [2];
    int sb_err;
    reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 100; s++) sq[p].push_back(tag(p, s));
    rand_ready = 1'b1;
    out_ready  = 1'($urandom_range(0, 1));
    drive();
    run_until(200, 3000);
    next_s[0] = 0;
    next_s[1] = 0;
    sb_err = 0;
    for (int k = 0; k < ow.size(); k++) begin
      int p;
      p = int'(op[k]);
      if (p > 1 || ow[k] !== tag(p, next_s[p])) sb_err++;
      else next_s[p]++;
    end
    total++; if (sb_err !== 0) $display("FAIL bp_order: got %0d bad words want 0", sb_err); else passed++;
    total++; if (next_s[0] !== 100) $display("FAIL bp_count0: got %0d want 100", next_s[0]); else passed++;
    total++; if (next_s[1] !== 100) $display("FAIL bp_count1: got %0d want 100", next_s[1]); else passed++;
    total++; if (stab_err !== 0) $display("FAIL bp_stable: got %0d changes want 0", stab_err); else passed++;
    total++; if (inv_err !== 0) $display("FAIL bp_in_ready_rule: got %0d violations want 0", inv_err); else passed++;
  endtask

  task automatic test_early_release();
    reset();
    for (int s = 0; s < 3; s++) sq[1].push_back(tag(1, s));
    for (int s = 0; s < 8; s++) sq[3].push_back(tag(3, s));
    drive();
    run_until(11, 100);
    for (int k = 0; k < 11; k++) begin
      int p;
      p = (k < 3) ? 1 : 3;
      total++; if (ow[k] !== tag(p, (k < 3) ? k : k - 3) || op[k] !== 2'(p))
        $display("FAIL early_word[%0d]: got %h port %0d want %h port %0d", k, ow[k], op[k], tag(p, (k < 3) ? k : k - 3), p);
      else passed++;
    end
    // Dry cycle plus one IDLE cycle between the last port-1 word and port 3.
    total++; if (oc[3] - oc[2] !== 3) $display("FAIL early_gap: got %0d cycles want 3", oc[3] - oc[2]); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    reset();
    for (int s = 0; s < 8; s++) sq[0].push_back(tag(0, s));
    for (int s = 0; s < 8; s++) sq[2].push_back(tag(2, s));
    out_ready = 1'b0;
    drive();
    repeat (4) cycle();
    total++; if (out_valid !== 1'b1) $display("FAIL mid_held_valid: got %b want 1", out_valid); else passed++;
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 4'b0) $display("FAIL mid_rst_in_ready: got %b want 0000", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    out_ready = 1'b1;
    drive();
    run_until(1, 20);
    // Word 0 of port 0 was in the discarded stage; port 0 resumes at word 1.
    total++; if (op[0] !== 2'd0) $display("FAIL mid_first_port: got %0d want 0", op[0]); else passed++;
    total++; if (ow[0] !== tag(0, 1)) $display("FAIL mid_first_word: got %h want %h", ow[0], tag(0, 1)); else passed++;
  endtask

  task automatic test_edge_params();
    int          e_seq [2];
    logic [1:0]  e_acc;
    int          n = 0;
    int          c = 0;
    logic [15:0] ed [$];
    logic [0:0]  ep [$];
    int          ec [$];
    reset();
    e_seq[0] = 0;
    e_seq[1] = 0;
    e_in_valid = 2'b11;
    e_in_data  = {tag(1, 0), tag(0, 0)};
    while (n < 8 && c < 60) begin
      @(negedge clk);
      e_acc = e_in_valid & e_in_ready;
      if (e_out_valid && e_out_ready) begin
        ed.push_back(e_out_data);
        ep.push_back(e_out_port);
        ec.push_back(c);
        n++;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) if (e_acc[p]) e_seq[p]++;
      e_in_data = {tag(1, e_seq[1]), tag(0, e_seq[0])};
      c++;
    end
    total++; if (n !== 8) $display("FAIL edge_timeout: got %0d words want 8", n); else passed++;
    for (int k = 0; k < n; k++) begin
      total++; if (ed[k] !== tag(k % 2, k / 2) || ep[k] !== 1'(k % 2))
        $display("FAIL edge_word[%0d]: got %h port %0d want %h port %0d", k, ed[k], ep[k], tag(k % 2, k / 2), k % 2);
      else passed++;
      if (k > 0) begin
        total++; if (ec[k] - ec[k-1] !== 2) $display("FAIL edge_gap[%0d]: got %0d want 2", k, ec[k] - ec[k-1]); else passed++;
      end
    end
    e_in_valid = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_valid   = '0;
    out_ready  = 1'b1;
    e_in_data  = '0;
    e_in_valid = '0;
    e_out_ready = 1'b1;
    test_reset();
    test_single_port();
    test_all_ports();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_edge_params();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/glip_out_arbiter.md
# glip_out_arbiter

Round-robin arbiter that shares the single GLIP Logic->Host FIFO channel (the `fifo_out_*` port of `glip_cypressfx3_toplevel`) between several user-logic streams, such as a loopback source and a status/measurement source. Each grant covers a bounded burst so no requester can starve the others. One registered output stage decouples the requesters' combinational paths from the FX3 backend's `fifo_out_ready`. The block sits between the user logic and `glip_cypressfx3_toplevel` in the same `clk` domain.

## Interface
- WIDTH, 16, data word width; must equal the GLIP `WIDTH` (16 or 32).
- NUM_PORTS, 4, number of requesters, 2..16.
- MAX_BURST, 8, maximum words per grant, 1..256.
- PORT_BITS, derived, `$clog2(NUM_PORTS)`; value 1 when NUM_PORTS=2.

Ports:
- clk  in  1  single clock; the GLIP `clk`. All logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_PORTS*WIDTH  requester i data, bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_PORTS  requester i has a word.
- in_ready  out  NUM_PORTS  requester i word accepted this cycle (valid & ready).
- out_data  out  WIDTH  to `fifo_out_data`.
- out_valid  out  1  to `fifo_out_valid`.
- out_ready  in  1  from `fifo_out_ready`.
- out_port  out  PORT_BITS  source index of the current out_data word.
- busy  out  1  high while in state BURST.

## Operation
- FSM has two states, IDLE and BURST. Registers: `grant` (PORT_BITS), `last` (PORT_BITS), `beat` (8 bits), output stage (`out_valid`, `out_data`, `out_port`).
- IDLE:
  - If any `in_valid` is high, the next state is BURST.
  - `grant` <= the first i with `in_valid[i]`=1, searching `last+1, last+2, …` modulo NUM_PORTS, with `last` checked last.
  - `beat` <= 0.
  - `in_ready` is all-zero in IDLE.
- BURST:
  - Define `stage_free = !out_valid || out_ready`.
  - `in_ready[grant] = stage_free`. All other `in_ready` bits are 0. This signal is combinational from registers and `out_ready` only, never from `in_valid`.
  - Transfer: `in_valid[grant] && in_ready[grant]`. On a transfer, the output stage loads `in_data[grant]`, `out_port` <= grant, `out_valid` <= 1, and `beat` <= `beat+1`.
  - If `stage_free` and there is no transfer, `out_valid` <= 0.
  - The burst ends (next state IDLE, `last` <= grant) when either:
    - a transfer occurs with `beat == MAX_BURST-1`, or
    - `in_valid[grant]` is 0 while `stage_free` is 1 (the requester has run dry).
  - If `stage_free` is 0 (backpressure), the burst is held regardless of `in_valid`.
- Output stage in IDLE: it drains only. `out_valid` <= 0 when `out_ready` is 1.
- Word order within a port is preserved. No word is dropped or duplicated under any `out_ready` pattern.
- Reset (`rst_n`=0, asynchronous): state IDLE, `grant`=0, `last`=NUM_PORTS-1 (so port 0 wins first), `beat`=0, `out_valid`=0, `out_data`=0, `out_port`=0, `busy`=0, `in_ready`=0.
- Reset asserted mid-burst discards any word held in the output stage. Requesters see `in_ready` drop immediately.

## Timing
- Latency from accepted input word to `out_valid`: 1 cycle.
- Arbitration bubble: 1 cycle in IDLE between bursts. Sustained throughput is MAX_BURST words per MAX_BURST+1 cycles when `out_ready`=1.
- `busy` equals (state == BURST) and is registered.
- `out_valid` and `out_data` are held stable while `out_valid && !out_ready`.
- A requester that deasserts `in_valid` mid-burst loses the grant one cycle later. It re-enters arbitration at the lowest priority only if it was `last`.
- A single active requester is re-granted after every burst. It suffers only the 1-cycle bubble.

## Test plan
- Single port, continuous traffic:
  - Stimulus: NUM_PORTS=4, MAX_BURST=8; port 2 streams 0x0000..0x0017 continuously; `out_ready`=1.
  - Required: 24 words out in order, `out_port`=2 throughout, an idle cycle after words 8 and 16, and 27 cycles total from the first grant.
- All ports requesting:
  - Stimulus: all four ports stream continuously, each word tagged port<<8|seq.
  - Required: bursts of 8 granted in order 0, 1, 2, 3, 0; no port exceeds 8 consecutive words.
- Random backpressure:
  - Stimulus: `out_ready` random at 50%; ports 0 and 1 send 100 words each.
  - Required: the scoreboard receives each port's sequence complete and in order; `out_data` is stable whenever valid is high and ready is low.
- Early release:
  - Stimulus: port 1 sends 3 words, then drops `in_valid`; port 3 is waiting.
  - Required: port 1's burst ends after 3 words; port 3 is granted after one IDLE cycle.
- Reset mid-burst:
  - Stimulus: assert `rst_n`=0 for 1 cycle asynchronously while `out_valid`=1 and `out_ready`=0.
  - Required: `out_valid`, `in_ready` and `busy` go to 0 immediately; after release, port 0 is granted first.
- Edge parameters:
  - Stimulus: MAX_BURST=1, NUM_PORTS=2, both ports streaming.
  - Required: the words strictly alternate 0, 1, 0, 1, with one bubble between each.
